// File: rtl/rom_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: ROM window defaults,
// the buffered fetch-entry layout and the fetch-address legality rule.
package rom_fetch_unit_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Word-aligned and inside [base, base + depth*4); 33-bit limit avoids wrap at the top of memory.
  function automatic logic pc_legal(input logic [31:0] pc,
                                    input logic [31:0] base,
                                    input int unsigned depth);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'(depth) * 33'(WORD_BYTES));
    return (pc[1:0] == 2'b00) && (pc >= base) && ({1'b0, pc} < limit);
  endfunction

endpackage

// File: rtl/rom_fetch_unit_fetch_buffer.sv
// Two-entry FIFO between the fetch sequencer and decode, with a synchronous
// flush that discards everything queued.
module fetch_buffer #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  // Handshake: head transfers on pop while valid; push is taken when not full
  // or when a pop frees the head slot in the same cycle; flush overrides both.
  logic [WIDTH-1:0] slot [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'd2) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign valid     = (count != 2'd0);
  assign head_data = valid ? slot[rd_ptr] : '0;

endmodule

// File: rtl/rom_fetch_unit.sv
// Fetch sequencer owning the ROM address port: holds fetch_pc, pushes one
// ROM word per cycle into the decode queue, handles redirects and faults.
module rom_fetch_unit
  import rom_fetch_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] Redirect_Address_i,
  input  logic                  Ready_i,
  output logic                  Valid_o,
  output logic [DATA_WIDTH-1:0] Instruction_o,
  output logic [DATA_WIDTH-1:0] Pc_o,
  output logic                  Fault_o,
  output logic [DATA_WIDTH-1:0] Rom_Address_o,
  input  logic [DATA_WIDTH-1:0] Rom_Instruction_i
);

  logic [DATA_WIDTH-1:0] fetch_pc;
  logic                  legal;
  logic                  push;
  logic                  pop;
  logic                  buf_valid;
  logic [1:0]            buf_count;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;

  assign legal = pc_legal(fetch_pc, RESET_PC, MEMORY_DEPTH);

  // Redirect suppresses both sides of the queue for its cycle.
  assign pop  = buf_valid & Ready_i & ~Redirect_i;
  assign push = legal & ~Redirect_i & ((buf_count != 2'd2) | pop);

  assign push_entry.pc    = fetch_pc;
  assign push_entry.instr = Rom_Instruction_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else if (Redirect_i) begin
      fetch_pc <= Redirect_Address_i;
    end else if (push) begin
      fetch_pc <= fetch_pc + DATA_WIDTH'(WORD_BYTES);
    end
  end

  fetch_buffer #(
    .WIDTH($bits(fetch_entry_t))
  ) u_buffer (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (Redirect_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .valid     (buf_valid),
    .head_data (head_entry),
    .count     (buf_count)
  );

  assign Valid_o       = buf_valid;
  assign Instruction_o = head_entry.instr;
  assign Pc_o          = head_entry.pc;
  assign Rom_Address_o = fetch_pc;
  // Fault waits for legal entries already queued to drain.
  assign Fault_o       = ~legal & (buf_count == 2'd0);

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed plus randomized bench for rom_fetch_unit against a queue-based
// reference model of the fetch rules, with a local ROM image.
module tb_rom_fetch_unit;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        Redirect_i;
  logic [31:0] Redirect_Address_i;
  logic        Ready_i;
  logic        Valid_o;
  logic [31:0] Instruction_o;
  logic [31:0] Pc_o;
  logic        Fault_o;
  logic [31:0] Rom_Address_o;
  logic [31:0] Rom_Instruction_i;

  logic [31:0] rom [DEPTH];
  logic [31:0] rom_off;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_pc;

  rom_fetch_unit dut (
    .clk                (clk),
    .reset              (reset),
    .Redirect_i         (Redirect_i),
    .Redirect_Address_i (Redirect_Address_i),
    .Ready_i            (Ready_i),
    .Valid_o            (Valid_o),
    .Instruction_o      (Instruction_o),
    .Pc_o               (Pc_o),
    .Fault_o            (Fault_o),
    .Rom_Address_o      (Rom_Address_o),
    .Rom_Instruction_i  (Rom_Instruction_i)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- ROM model ----------------
  function automatic logic ref_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  always_comb begin
    rom_off           = Rom_Address_o - BASE;
    Rom_Instruction_i = 32'hdead_beef;
    if (ref_legal(Rom_Address_o)) Rom_Instruction_i = rom[rom_off[7:2]];
  end

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    int idx;
    idx = int'((a - BASE) / 4);
    return rom[idx];
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    exp_q.delete();
    m_pc = BASE;
  endtask

  task automatic model_edge(input logic rd, input logic [31:0] ra, input logic rdy);
    logic do_pop;
    logic do_push;
    if (rd) begin
      exp_q.delete();
      m_pc = ra;
    end else begin
      do_pop  = (exp_q.size() != 0) && rdy;
      do_push = ref_legal(m_pc) && ((exp_q.size() < 2) || do_pop);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back({m_pc, rom_at(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [63:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 64'd0;
    chk({tag, ".valid"}, {31'd0, Valid_o}, {31'd0, exp_q.size() != 0});
    chk({tag, ".pc"}, Pc_o, head[63:32]);
    chk({tag, ".instr"}, Instruction_o, head[31:0]);
    chk({tag, ".fault"}, {31'd0, Fault_o}, {31'd0, !ref_legal(m_pc) && exp_q.size() == 0});
    chk({tag, ".rom_addr"}, Rom_Address_o, m_pc);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rd, input logic [31:0] ra, input logic rdy);
    Redirect_i         = rd;
    Redirect_Address_i = ra;
    Ready_i            = rdy;
    @(posedge clk);
    model_edge(rd, ra, rdy);
    #1;
    check_model("step");
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".valid"}, {31'd0, Valid_o}, 32'd0);
    chk({tag, ".instr"}, Instruction_o, 32'd0);
    chk({tag, ".pc"}, Pc_o, 32'd0);
    chk({tag, ".fault"}, {31'd0, Fault_o}, 32'd0);
    chk({tag, ".rom_addr"}, Rom_Address_o, BASE);
  endtask

  task automatic apply_reset();
    Redirect_i = 1'b0;
    Ready_i    = 1'b0;
    reset      = 1'b0;
    #1;
    check_reset_values("reset_async");
    @(posedge clk);
    #1;
    check_reset_values("reset_held");
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] last_pc;
    logic [31:0] addr;
    reset              = 1'b0;
    Redirect_i         = 1'b0;
    Redirect_Address_i = 32'd0;
    Ready_i            = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b1;

    // streaming from reset with Ready_i high
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'd0, 1'b1);
      chk("stream_pc", Pc_o, BASE + 32'(4 * i));
      chk("stream_instr", Instruction_o, rom[i]);
    end

    // backpressure after reset: buffer fills, fetch stalls
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0);
    chk("stall_rom_addr", Rom_Address_o, BASE + 32'h8);
    chk("stall_valid", {31'd0, Valid_o}, 32'd1);
    chk("stall_head", Pc_o, BASE);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", Pc_o, BASE + 32'(4 * i));
      step(1'b0, 32'd0, 1'b1);
    end

    // redirect while full flushes queued entries
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    chk("full_valid", {31'd0, Valid_o}, 32'd1);
    step(1'b1, BASE + 32'h10, 1'b1);
    chk("redirect_empty", {31'd0, Valid_o}, 32'd0);
    step(1'b0, 32'd0, 1'b1);
    chk("redirect_pc", Pc_o, BASE + 32'h10);
    step(1'b0, 32'd0, 1'b1);
    chk("redirect_next", Pc_o, BASE + 32'h14);

    // run to the end of the ROM window
    last_pc = 32'd0;
    for (int i = 0; i < 100; i++) begin
      if (Valid_o) last_pc = Pc_o;
      if (!ref_legal(m_pc) && exp_q.size() == 0) break;
      step(1'b0, 32'd0, 1'b1);
    end
    chk("end_last_pc", last_pc, BASE + 32'hfc);
    chk("end_valid", {31'd0, Valid_o}, 32'd0);
    chk("end_fault", {31'd0, Fault_o}, 32'd1);
    step(1'b0, 32'd0, 1'b1);
    chk("end_fault_hold", {31'd0, Fault_o}, 32'd1);
    step(1'b1, BASE, 1'b1);
    chk("recover_fault", {31'd0, Fault_o}, 32'd0);
    step(1'b0, 32'd0, 1'b1);
    chk("recover_pc", Pc_o, BASE);

    // illegal redirect targets
    step(1'b1, BASE + 32'h2, 1'b1);
    chk("misalign_fault", {31'd0, Fault_o}, 32'd1);
    step(1'b0, 32'd0, 1'b1);
    chk("misalign_valid", {31'd0, Valid_o}, 32'd0);
    step(1'b1, BASE - 32'h4, 1'b1);
    chk("below_fault", {31'd0, Fault_o}, 32'd1);
    step(1'b0, 32'd0, 1'b1);
    chk("below_valid", {31'd0, Valid_o}, 32'd0);
    step(1'b1, BASE + 32'h40, 1'b1);
    chk("legal_again_fault", {31'd0, Fault_o}, 32'd0);

    // randomized traffic and redirects
    for (int i = 0; i < 400; i++) begin
      addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      case ($urandom_range(0, 9))
        6: addr = BASE + 32'(4 * $urandom_range(DEPTH - 4, DEPTH - 1));
        7: addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1)) | 32'd1;
        8: addr = BASE - 32'h4;
        9: addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        default: ;
      endcase
      step($urandom_range(0, 19) == 0, addr, $urandom_range(0, 3) != 0);
    end

    // asynchronous reset with two entries buffered
    step(1'b1, BASE + 32'h20, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    chk("pre_reset_valid", {31'd0, Valid_o}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("midstream_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_model("reset_hold");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);
    chk("post_reset_pc", Pc_o, BASE + 32'hc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
